// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the sequential ALU and its iteration datapath.
//   DEFAULT_WIDTH   default operand/result width
//   OP_*            4-bit operation codes (1010..1111 are illegal)
//   state_t         control FSM encoding: ST_IDLE, ST_ITER, ST_FIN
package alu_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_SLTU = 4'b0010;
  localparam logic [3:0] OP_SRL  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: shared shift-add multiply / restoring divide datapath.
// One product or quotient bit is produced per cycle while run=1.
// Configuration macro: SEQ_ALU_DIV_EN (when undefined only multiply exists).
// Ports:
//   clk, srst        clock, synchronous active-high reset
//   load             capture a/b and preset counter to WIDTH-1
//   run              perform one iteration step this cycle
//   is_div           (SEQ_ALU_DIV_EN only) loaded op is a divide
//   a, b             operands (multiplier/dividend, multiplicand/divisor)
//   lo_step/hi_step  value the low/high registers take after this step
//                    (MUL: product low/high, DIVU: quotient/remainder)
//   last             counter has reached 0: current step is the final one
module seq_alu_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic             run,
`ifdef SEQ_ALU_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo_step,
  output logic [WIDTH-1:0] hi_step,
  output logic             last
);

  logic [WIDTH-1:0] acc_q, acc_d;   // product high word / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;     // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] opb_q, opb_d;   // multiplicand / divisor
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
`ifdef SEQ_ALU_DIV_EN
  logic             div_q, div_d;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
`endif

  always_comb begin
    // Shift-add: add multiplicand if the current multiplier LSB is set, then
    // shift {acc, mq} right by one so the product assembles across both words.
    mul_sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
    hi_step = mul_sum[WIDTH:1];
    lo_step = {mul_sum[0], mq_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    // Restoring divide: shift the next dividend bit into the remainder and
    // trial-subtract. The extra top bit of div_diff is the borrow. With b=0
    // every trial succeeds, which naturally yields all-ones and remainder=a.
    div_shift = {acc_q, mq_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (div_q) begin
      if (!div_diff[WIDTH]) begin
        hi_step = div_diff[WIDTH-1:0];
        lo_step = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_step = div_shift[WIDTH-1:0];
        lo_step = {mq_q[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

  always_comb begin
    acc_d = acc_q;
    mq_d  = mq_q;
    opb_d = opb_q;
    cnt_d = cnt_q;
`ifdef SEQ_ALU_DIV_EN
    div_d = div_q;
`endif
    if (load) begin
      acc_d = '0;
      mq_d  = a;
      opb_d = b;
      cnt_d = CNT_W'(WIDTH - 1);
`ifdef SEQ_ALU_DIV_EN
      div_d = is_div;
`endif
    end else if (run) begin
      acc_d = hi_step;
      mq_d  = lo_step;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      acc_q <= '0;
      mq_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      acc_q <= acc_d;
      mq_q  <= mq_d;
      opb_q <= opb_d;
      cnt_q <= cnt_d;
`ifdef SEQ_ALU_DIV_EN
      div_q <= div_d;
`endif
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with registered single-cycle ops plus iterative
// unsigned MUL and (optionally) DIVU, driven by a start/busy/done handshake.
// Configuration macro: SEQ_ALU_DIV_EN enables DIVU; otherwise op 1001 is
// treated as illegal and div_by_zero is tied low.
// Ports:
//   CLK, Reset     clock, synchronous active-high reset
//   start, op      request pulse and op code (ignored while busy)
//   a, b           operands, sampled with an accepted start
//   busy           multi-cycle op iterating
//   done           one-cycle completion pulse
//   result         primary result (held until next done)
//   result_hi      MUL high word / DIVU remainder, else 0
//   zero           result == 0 for the completed op
//   div_by_zero    last completed op was DIVU with b == 0
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_by_zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             accept, is_multi, iter_load, iter_last;
  logic [WIDTH-1:0] single_res, iter_lo, iter_hi;
  logic             shift_oob;
`ifdef SEQ_ALU_DIV_EN
  logic             div_op_q, div_op_d;
  logic             b_zero_q, b_zero_d;
  logic             dbz_q, dbz_d;
  logic             is_div;
`endif

  // WIDTH is a power of two, so any set bit above the shift-amount field
  // means b >= WIDTH.
  assign shift_oob = (b[WIDTH-1:CNT_W] != '0);

  always_comb begin
    case (op)
      OP_ADD:  single_res = a + b;
      OP_SUB:  single_res = a - b;
      OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SRL:  single_res = shift_oob ? '0 : (a >> b[CNT_W-1:0]);
      OP_SLL:  single_res = shift_oob ? '0 : (a << b[CNT_W-1:0]);
      OP_OR:   single_res = a | b;
      OP_AND:  single_res = a & b;
      OP_XOR:  single_res = a ^ b;
      default: single_res = '0;
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  assign is_div   = (op == OP_DIVU);
  assign is_multi = (op == OP_MUL) || is_div;
`else
  assign is_multi = (op == OP_MUL);
`endif

  assign accept = start && (state_q != ST_ITER);

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    iter_load   = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    div_op_d    = div_op_q;
    b_zero_d    = b_zero_q;
    dbz_d       = dbz_q;
`endif
    if (state_q == ST_ITER) begin
      // Latch the final step's values on the same edge that enters FIN.
      if (iter_last) begin
        state_d     = ST_FIN;
        result_d    = iter_lo;
        result_hi_d = iter_hi;
        zero_d      = (iter_lo == '0);
`ifdef SEQ_ALU_DIV_EN
        dbz_d       = div_op_q && b_zero_q;
`endif
      end
    end else if (accept) begin
      if (is_multi) begin
        state_d   = ST_ITER;
        iter_load = 1'b1;
`ifdef SEQ_ALU_DIV_EN
        div_op_d  = is_div;
        b_zero_d  = (b == '0);
`endif
      end else begin
        state_d     = ST_FIN;
        result_d    = single_res;
        result_hi_d = '0;
        zero_d      = (single_res == '0);
`ifdef SEQ_ALU_DIV_EN
        dbz_d       = 1'b0;
`endif
      end
    end else if (state_q == ST_FIN) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b1;
`ifdef SEQ_ALU_DIV_EN
      div_op_q    <= 1'b0;
      b_zero_q    <= 1'b0;
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
`ifdef SEQ_ALU_DIV_EN
      div_op_q    <= div_op_d;
      b_zero_q    <= b_zero_d;
      dbz_q       <= dbz_d;
`endif
    end
  end

  seq_alu_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk     (CLK),
    .srst    (Reset),
    .load    (iter_load),
    .run     (state_q == ST_ITER),
`ifdef SEQ_ALU_DIV_EN
    .is_div  (is_div),
`endif
    .a       (a),
    .b       (b),
    .lo_step (iter_lo),
    .hi_step (iter_hi),
    .last    (iter_last)
  );

  assign busy      = (state_q == ST_ITER);
  assign done      = (state_q == ST_FIN);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
`ifdef SEQ_ALU_DIV_EN
  assign div_by_zero = dbz_q;
`else
  assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (WIDTH=32). The driver pushes the
// expected completion (values and done cycle) when it issues an op; a monitor
// pops and compares on every done pulse.
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = 4'b0000;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, zero, div_by_zero;
  logic [W-1:0] result, result_hi;

  seq_alu dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .result_hi   (result_hi),
    .zero        (zero),
    .div_by_zero (div_by_zero)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         dbz;
    int           at;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: one line per completed transaction.
  always @(negedge CLK) begin
    if (!Reset && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'(result), 64'hDEAD_0000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("[TB] done %s cyc=%0d result=0x%08h hi=0x%08h zero=%0b dbz=%0b",
                 e.name, cyc, result, result_hi, zero, div_by_zero);
        chk({e.name, "_result"}, 64'(result), 64'(e.res));
        chk({e.name, "_hi"}, 64'(result_hi), 64'(e.hi));
        chk({e.name, "_zero"}, 64'(zero), 64'(e.res == '0));
        chk({e.name, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.at));
      end
    end
  end

  // Drive one start; the op is sampled at the next posedge (cycle cyc+1).
  task automatic issue(input string name, input logic [3:0] o, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] er, input logic [W-1:0] eh,
                       input logic ed, input int lat);
    exp_t e;
    @(negedge CLK);
    start = 1'b1; op = o; a = av; b = bv;
    e.name = name; e.res = er; e.hi = eh; e.dbz = ed; e.at = cyc + 1 + lat;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge CLK);
  endtask

  initial begin
    int t0;
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_hi", 64'(result_hi), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_dbz", 64'(div_by_zero), 64'd0);
    Reset = 1'b0;

    // Back-to-back single-cycle ops.
    issue("add", OP_ADD, 32'd5, 32'd7, 32'd12, '0, 1'b0, 0);
    issue("sub", OP_SUB, 32'd7, 32'd7, 32'd0, '0, 1'b0, 0);
    issue("srl", OP_SRL, 32'h8000_0000, 32'd31, 32'd1, '0, 1'b0, 0);
    issue("sll_oob", OP_SLL, 32'h0000_0001, 32'd32, 32'd0, '0, 1'b0, 0);
    issue("sltu", OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd1, '0, 1'b0, 0);
    issue("xor", OP_XOR, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, '0, 1'b0, 0);
    issue("illegal", 4'b1010, 32'd5, 32'd5, 32'd0, '0, 1'b0, 0);
    idle();
    drain("single");

    // MUL with ignored start pulses while busy.
    issue("mul", OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd1, 1'b0, W);
    t0 = cyc + 1;
    @(negedge CLK);
    chk("mul_busy_first", 64'(busy), 64'd1);
    op = OP_ADD; a = 32'd3; b = 32'd4;
    repeat (5) @(negedge CLK);
    start = 1'b0;
    while (cyc < t0 + W - 1) @(negedge CLK);
    chk("mul_busy_last", 64'(busy), 64'd1);
    @(negedge CLK);
    chk("mul_busy_fin", 64'(busy), 64'd0);
    drain("mul");

    issue("mul_max", OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, W);
    idle();
    drain("mul_max");

`ifdef SEQ_ALU_DIV_EN
    issue("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W);
    idle();
    drain("divu");
    issue("divu_by0", OP_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1, W);
    idle();
    drain("divu_by0");
    issue("add_clr", OP_ADD, 32'd1, 32'd2, 32'd3, '0, 1'b0, 0);
    idle();
    drain("add_clr");
`else
    issue("div_off", OP_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 0);
    idle();
    drain("div_off");
`endif

    // Reset during MUL iteration discards the op.
    issue("mul_rst", OP_MUL, 32'd3, 32'd5, 32'd15, '0, 1'b0, W);
    idle();
    repeat (9) @(negedge CLK);
    Reset = 1'b1;
    exp_q.delete();
    @(negedge CLK);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_zero", 64'(zero), 64'd1);
    chk("midrst_done", 64'(done), 64'd0);
    // start concurrent with reset is dropped.
    start = 1'b1; op = OP_ADD; a = 32'd1; b = 32'd1;
    @(negedge CLK);
    start = 1'b0;
    Reset = 1'b0;
    chk("rst_start_done", 64'(done), 64'd0);
    repeat (40) @(negedge CLK);

    issue("add_post", OP_ADD, 32'd20, 32'd22, 32'd42, '0, 1'b0, 0);
    idle();
    drain("add_post");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, sequential successor to the datapath's combinational ALU.
- Keeps the eight single-cycle operations, now with registered results.
- Adds iterative unsigned multiply and divide, completed over WIDTH cycles.
- Sits between the A/B operand registers and ALUOut; the multicycle control FSM drives it with a start/busy/done handshake.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 4, power of two).
- CNT_W, $clog2(WIDTH), width of the iteration counter (derived; do not override).

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; ignored while busy=1.
- op  input  4  operation code, sampled with start.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B (already muxed with immediate), sampled with start.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse; result, result_hi and zero are valid and held until the next done.
- result  output  WIDTH  primary result.
- result_hi  output  WIDTH  MUL high word or DIVU remainder; 0 for all other ops.
- zero  output  1  result == 0 for the completed operation.
- div_by_zero  output  1  last completed DIVU had b == 0.

Behaviour:
- Op codes:
  - 0000 ADD, 0001 SUB, 0010 SLTU (1 if a<b unsigned), 0011 SRL, 0100 SLL, 0101 OR, 0110 AND, 0111 XOR.
  - 1000 MUL (unsigned 2*WIDTH product: low word to result, high word to result_hi).
  - 1001 DIVU (quotient to result, remainder to result_hi).
  - 1010..1111: illegal; single-cycle with result=0, result_hi=0.
- ADD/SUB wrap modulo 2^WIDTH.
- Shifts: when b >= WIDTH, result=0. Otherwise shift by b.
- FSM states: IDLE, ITER, FIN. busy = (state==ITER). done = (state==FIN).
- Start acceptance: start is accepted in IDLE or FIN, so back-to-back issue is allowed. In ITER, start is ignored and operands are not resampled.
- Single-cycle ops: start at cycle t -> state FIN at t+1 with outputs updated (latency 1).
- MUL/DIVU: start at t -> ITER for cycles t+1..t+WIDTH, counter counting WIDTH-1 down to 0 -> FIN at t+WIDTH+1.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIVU: restoring, one quotient bit per cycle.
- FIN with no start -> IDLE. FIN with start -> next op as from IDLE.
- Outputs update only on entry to FIN. They hold through IDLE and ITER.
- div_by_zero:
  - DIVU with b=0: result = all ones, result_hi = a, div_by_zero=1. Latency is still WIDTH+1, so timing does not depend on data.
  - div_by_zero clears on the next completed op.
- Reset, at any time including mid-ITER:
  - state=IDLE, counter=0.
  - busy=0, done=0, result=0, result_hi=0, zero=1, div_by_zero=0.
  - The in-flight operation is discarded with no done.
- start asserted in the same cycle as Reset: Reset wins and start is dropped.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined: DIVU is implemented as above.
- Undefined:
  - Op 1001 behaves as illegal (single-cycle, result=0, result_hi=0).
  - div_by_zero is tied to 0.
  - The divider datapath and remainder register are removed.

Decomposition:
- Shared package alu_pkg holds:
  - op-code localparams: OP_ADD .. OP_DIVU.
  - state encoding constants: ST_IDLE, ST_ITER, ST_FIN.
  - the default WIDTH.
- One sub-module, seq_alu_iter: the shared multiply/divide iteration datapath (accumulator, shifting operand, counter).
- Single-cycle ops and the FSM stay in seq_alu.

Test Plan:
- WIDTH=32: ADD a=5,b=7 at t -> done at t+1, result=12, zero=0. Then SUB 7-7 next cycle -> result=0, zero=1, done at t+2 (back-to-back).
- SRL a=0x80000000,b=31 -> result=1. SLL with b=32 -> result=0. SLTU a=1,b=0xFFFFFFFF -> result=1.
- MUL a=0x00010000,b=0x00010000 at t -> busy for t+1..t+32, done at t+33, result=0, result_hi=1. Start pulses during busy are ignored and operands stay unchanged.
- DIVU 100/7 -> result=14, result_hi=2, done at t+33. DIVU 9/0 -> result=0xFFFFFFFF, result_hi=9, div_by_zero=1. A following ADD clears div_by_zero.
- Reset asserted at cycle 10 of a MUL -> next cycle busy=0, result=0, zero=1, and no done pulse follows. A new ADD then completes normally.
- SEQ_ALU_DIV_EN undefined: op 1001 with a=100,b=7 -> done at t+1, result=0, div_by_zero=0.
